// File: rtl/traffic_disp_pkg.sv
// Shared definitions for the traffic-light countdown display.
// Contents: active-low seven-segment patterns ({g,f,e,d,c,b,a}), the blank
// pattern, the converter FSM state type, the scan digit indices and a
// BCD-to-segment decode helper.
package traffic_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } conv_state_t;

  // Scan index of each digit; the matching enable is an[index].
  localparam logic [1:0] IDX_A_TENS = 2'd3;
  localparam logic [1:0] IDX_A_ONES = 2'd2;
  localparam logic [1:0] IDX_B_TENS = 2'd1;
  localparam logic [1:0] IDX_B_ONES = 2'd0;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bin6_to_bcd.sv
// Sequential double-dabble converter, 6-bit binary to two BCD digits.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   start     begin a conversion (accepted only in IDLE)
//   bin       value to convert; must stay stable until done
//   done      high for the single LOAD cycle; tens/ones are valid then
//   tens      BCD tens digit, 0..6
//   ones      BCD ones digit, 0..9
// Sequence: IDLE --start--> CONV (6 shift steps) --> LOAD --> IDLE.
module bin6_to_bcd
  import traffic_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       done,
  output logic [2:0] tens,
  output logic [3:0] ones
);

  conv_state_t state;
  conv_state_t state_nxt;
  logic [2:0]  step;
  logic [5:0]  shreg;

  logic [5:0]  src;
  logic [3:0]  ones_adj;
  logic [2:0]  tens_shift;
  logic [3:0]  ones_shift;
  logic [5:0]  shreg_shift;

  // Step 0 reads bin directly: the caller's snapshot register is written on
  // the same edge that starts the conversion, so it is only stable from the
  // following cycle. Later steps work from the internal shift register.
  // The tens digit never exceeds 3 before a shift for a 6-bit input, so it
  // never needs the add-3 correction.
  always_comb begin
    src         = (step == 3'd0) ? bin : shreg;
    ones_adj    = (ones >= 4'd5) ? ones + 4'd3 : ones;
    tens_shift  = {tens[1:0], ones_adj[3]};
    ones_shift  = {ones_adj[2:0], src[5]};
    shreg_shift = {src[4:0], 1'b0};
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CONV;
      CONV: if (step == 3'd5) state_nxt = LOAD;
      LOAD: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      shreg <= '0;
      tens  <= '0;
      ones  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            step <= '0;
            tens <= '0;
            ones <= '0;
          end
        end
        CONV: begin
          tens  <= tens_shift;
          ones  <= ones_shift;
          shreg <= shreg_shift;
          step  <= step + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // A new start can only arrive in IDLE while the scan period is at least
  // 8 cycles; anything else means the conversion would be corrupted.
  start_only_when_idle: assert property (@(posedge clk) disable iff (rst)
    start |-> state == IDLE);

endmodule

// File: rtl/traffic_time_display.sv
// Four-digit multiplexed seven-segment driver for the traffic-light
// countdown values.
// Parameters:
//   SCAN_DIV  clock cycles each digit stays enabled (>= 8)
// Ports:
//   CLK, RST  system clock, synchronous active-high reset
//   A_time    main-road remaining time, 0..63
//   B_time    side-road remaining time, 0..63
//   seg       active-low segments {g,f,e,d,c,b,a}
//   an        active-low digit enables: [3] A tens, [2] A ones,
//             [1] B tens, [0] B ones
// Inputs are snapshotted once per frame (terminal count with idx==3) and
// converted to BCD; display registers update 7 cycles after the snapshot.
module traffic_time_display
  import traffic_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] A_time,
  input  logic [5:0] B_time,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int unsigned   PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic          terminal;
  logic          frame_start;

  logic [5:0]    a_snap;
  logic [5:0]    b_snap;
  logic [2:0]    a_tens;
  logic [3:0]    a_ones;
  logic [2:0]    b_tens;
  logic [3:0]    b_ones;

  logic          a_done;
  logic          b_done;
  logic [2:0]    a_tens_c;
  logic [3:0]    a_ones_c;
  logic [2:0]    b_tens_c;
  logic [3:0]    b_ones_c;

  logic [6:0]    digit_seg;
  logic [3:0]    an_nxt;

  bin6_to_bcd u_conv_a (
    .clk   (CLK),
    .rst   (RST),
    .start (frame_start),
    .bin   (a_snap),
    .done  (a_done),
    .tens  (a_tens_c),
    .ones  (a_ones_c)
  );

  bin6_to_bcd u_conv_b (
    .clk   (CLK),
    .rst   (RST),
    .start (frame_start),
    .bin   (b_snap),
    .done  (b_done),
    .tens  (b_tens_c),
    .ones  (b_ones_c)
  );

  always_comb begin
    terminal    = (pcnt == PMAX);
    frame_start = terminal && (idx == 2'd3);
    idx_nxt     = idx + 2'd1;
    an_nxt      = ~(4'b0001 << idx_nxt);
  end

  // Pattern for the digit about to be enabled; zero tens digits are blanked.
  always_comb begin
    digit_seg = SEG_BLANK;
    case (idx_nxt)
      IDX_A_TENS: digit_seg = (a_tens == 3'd0) ? SEG_BLANK : seg_decode({1'b0, a_tens});
      IDX_A_ONES: digit_seg = seg_decode(a_ones);
      IDX_B_TENS: digit_seg = (b_tens == 3'd0) ? SEG_BLANK : seg_decode({1'b0, b_tens});
      IDX_B_ONES: digit_seg = seg_decode(b_ones);
      default:    digit_seg = SEG_BLANK;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt   <= '0;
      idx    <= 2'd3;
      seg    <= SEG_BLANK;
      an     <= '1;
      a_snap <= '0;
      b_snap <= '0;
      a_tens <= '0;
      a_ones <= '0;
      b_tens <= '0;
      b_ones <= '0;
    end else begin
      pcnt <= terminal ? '0 : pcnt + PW'(1);
      if (terminal) begin
        idx <= idx_nxt;
        an  <= an_nxt;
        seg <= digit_seg;
      end
      if (frame_start) begin
        a_snap <= A_time;
        b_snap <= B_time;
      end
      if (a_done) begin
        a_tens <= a_tens_c;
        a_ones <= a_ones_c;
      end
      if (b_done) begin
        b_tens <= b_tens_c;
        b_ones <= b_ones_c;
      end
    end
  end

endmodule

// File: tb/tb_traffic_time_display.sv
// Scoreboard bench for traffic_time_display (SCAN_DIV = 8).
// The stimulus process knows when each frame starts, computes the four
// digits from the captured inputs with plain decimal arithmetic and queues
// the expected (cycle, an, seg) for every scan step. The monitor pops an
// entry whenever an changes and also checks the outputs hold steady between
// scan steps.
module tb_traffic_time_display;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] A_time = '0;
  logic [5:0] B_time = '0;
  logic [6:0] seg;
  logic [3:0] an;

  traffic_time_display #(.SCAN_DIV(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .A_time (A_time),
    .B_time (B_time),
    .seg    (seg),
    .an     (an)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int off;
  } plan_t;

  exp_t  sbq[$];
  plan_t plan_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    prev_b   = 0;

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Edges since the last reset release.
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

  function automatic logic [6:0] ones_seg(input int v);
    return pat[v % 10];
  endfunction

  function automatic logic [6:0] tens_seg(input int v);
    return (v / 10 == 0) ? 7'h7F : pat[v / 10];
  endfunction

  function automatic void check(input bit ok, input string name,
                                input logic [3:0] ga, input logic [6:0] gs, input int gt,
                                input logic [3:0] wa, input logic [6:0] ws, input int wt);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got an=%b seg=%h cyc=%0d, want an=%b seg=%h cyc=%0d",
                  name, ga, gs, gt, wa, ws, wt);
  endfunction

  // Monitor
  logic [3:0] prev_an  = 4'hF;
  bit         have_cur = 1'b0;
  exp_t       cur;

  always @(negedge CLK) begin
    if (RST) begin
      prev_an  = 4'hF;
      have_cur = 1'b0;
    end else begin
      if (an !== prev_an) begin
        if (sbq.size() == 0) begin
          check(1'b0, "unexpected_scan", an, seg, cyc, 4'hF, 7'h7F, -1);
        end else begin
          cur      = sbq.pop_front();
          have_cur = 1'b1;
          check(an === cur.an && seg === cur.seg && cyc == cur.t, "scan",
                an, seg, cyc, cur.an, cur.seg, cur.t);
        end
      end else if (have_cur) begin
        check(an === cur.an && seg === cur.seg, "hold", an, seg, cyc, cur.an, cur.seg, cyc);
      end else begin
        check(an === 4'hF && seg === 7'h7F, "pre_scan_blank", an, seg, cyc, 4'hF, 7'h7F, cyc);
      end
      prev_an = an;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic plan_t next_plan();
    plan_t p;
    if (plan_q.size() > 0) begin
      p = plan_q.pop_front();
    end else begin
      p.a   = int'($urandom_range(0, 63));
      p.b   = int'($urandom_range(0, 63));
      p.off = int'($urandom_range(1, 31));
    end
    return p;
  endfunction

  // Runs n frames from a reset release. Inputs change once per frame at a
  // planned offset after the frame start; the value present at the next
  // frame start is what gets displayed. Ends 3 cycles into the last frame
  // (converter busy) when end_reset is set.
  task automatic run_frames(input int n, input bit end_reset);
    int    fs;
    int    nfs;
    int    cap_a;
    int    cap_b;
    bit    pend;
    plan_t p;
    fs   = -1;
    nfs  = 0;
    pend = 1'b0;
    p    = '{0, 0, 1};
    while (1) begin
      tick();
      if (cyc >= 8 && (cyc - 8) % 32 == 0) begin
        cap_a = int'(A_time);
        cap_b = int'(B_time);
        sbq.push_back('{cyc,      4'b1110, ones_seg(prev_b)});
        sbq.push_back('{cyc + 8,  4'b1101, tens_seg(cap_b)});
        sbq.push_back('{cyc + 16, 4'b1011, ones_seg(cap_a)});
        sbq.push_back('{cyc + 24, 4'b0111, tens_seg(cap_a)});
        prev_b = cap_b;
        nfs++;
        fs   = cyc;
        p    = next_plan();
        pend = 1'b1;
      end
      if (pend && fs >= 0 && cyc == fs + p.off) begin
        A_time = 6'(p.a);
        B_time = 6'(p.b);
        pend   = 1'b0;
      end
      if (nfs == n && cyc == fs + (end_reset ? 3 : 28)) break;
    end
  endtask

  initial begin
    // Values set after frame k's start, captured at frame k+1's start.
    plan_q.push_back('{27, 17, 5});
    plan_q.push_back('{12, 17, 1});   // 27 stays for this frame
    plan_q.push_back('{5,  0,  10});
    plan_q.push_back('{63, 59, 20});
    plan_q.push_back('{0,  0,  31});
    plan_q.push_back('{10, 9,  3});
    plan_q.push_back('{59, 63, 17});

    A_time = 6'd27;
    B_time = 6'd17;
    RST    = 1'b1;
    repeat (3) tick();
    check(an === 4'hF && seg === 7'h7F, "reset", an, seg, cyc, 4'hF, 7'h7F, cyc);
    RST    = 1'b0;
    prev_b = 0;

    run_frames(12, 1'b1);

    RST = 1'b1;
    sbq.delete();
    tick();
    check(an === 4'hF && seg === 7'h7F, "reset_mid_conv", an, seg, cyc, 4'hF, 7'h7F, cyc);
    tick();
    tick();
    RST    = 1'b0;
    prev_b = 0;

    run_frames(5, 1'b0);

    for (int i = 0; i < 40 && sbq.size() > 0; i++) tick();
    check(sbq.size() == 0, "drain", an, seg, sbq.size(), an, seg, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_time_display.md
# traffic_time_display

Multiplexed four-digit seven-segment driver for the traffic-light countdown values. Consumes the 6-bit main-road and side-road remaining-time buses produced by the traffic-light controller. Converts each value to two BCD digits with a sequential double-dabble converter and time-multiplexes them onto one shared active-low segment bus. Sits between the controller's time outputs and the board's display pins.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays enabled; legal range ≥ 8.
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- A_time  in  6  main-road remaining time, 0..63, unsigned binary.
- B_time  in  6  side-road remaining time, 0..63, unsigned binary.
- seg  out  7  active-low segments, {g,f,e,d,c,b,a}.
- an  out  4  active-low digit enables:
  - an[3]: A tens.
  - an[2]: A ones.
  - an[1]: B tens.
  - an[0]: B ones.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. Terminal means `pcnt==SCAN_DIV-1`.
- On terminal, digit index `idx` (2 bits) advances and wraps 3→0.
- Frame start is a terminal with `idx==3`.
- Scan output on each terminal, registered:
  - `an` becomes one-hot-low at the new `idx`.
  - `seg` becomes the pattern of the digit at the new `idx`.
- Snapshot:
  - At frame start, latch A_time and B_time into snapshot registers.
  - Converter FSM then goes IDLE→CONV.
- Converter FSM:
  - IDLE: wait for frame start.
  - CONV: 6 shift steps of add-3 double dabble, both roads in parallel, `step` counter 0..5.
  - LOAD: write A_tens, A_ones, B_tens, B_ones display registers, then return to IDLE.
- Frame start while not in IDLE cannot occur, because SCAN_DIV ≥ 8. Debug assertion: flag it if it ever does.
- BCD ranges: tens 0..6, ones 0..9.
- Segment patterns (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Leading-zero blanking: a tens digit of 0 drives seg=7F while its enable is low. Ones digits are never blanked, so 0 displays as "0".
- Inputs are sampled only at frame start. Changes between frame starts are ignored until the next frame start.

## Timing
- Reset values: seg=7F, an=F, pcnt=0, idx=3, FSM=IDLE, snapshot registers=0, all display registers=0.
- With idx=3 at reset, the first terminal is a frame start. It enables an[0] (1110) and starts the first conversion.
- Conversion latency: frame-start edge at cycle t; LOAD writes display registers at edge t+7.
- New values appear on each digit at that digit's next enable after t+7.
  - an[0] shows the previous value during the frame in which the capture occurred.
  - an[1..3] show the new value in the same frame.
- Each digit is enabled for exactly SCAN_DIV cycles. Full frame is 4·SCAN_DIV cycles.
- an and seg change on the same edge. Each digit has no glitch cycle with mixed old/new content.
- RST asserted at any point, including mid-CONV: all registers take reset values on that edge and the conversion is abandoned. Behaviour after release is identical to power-up.

## Structure
- Package `traffic_disp_pkg` holds:
  - the ten segment-pattern constants and SEG_BLANK = 7F;
  - the FSM state enum (IDLE, CONV, LOAD);
  - the digit-index constants for A tens, A ones, B tens, B ones.
- Sub-module `bin6_to_bcd`:
  - sequential double dabble;
  - ports: start, bin[5:0], done, tens[2:0], ones[3:0];
  - instantiated twice, once per road.
- The top holds the prescaler, scan counter, snapshot registers, and the output mux and decode.

## Test plan
All scenarios use SCAN_DIV=8.
1. Reset: hold RST 3 cycles → seg=7F, an=F. After release, an stays F for 8 cycles, then an=1110.
2. A_time=27, B_time=17 held:
   - from the second frame, an[3] low→seg 24;
   - an[2]→78;
   - an[1]→79;
   - an[0]→78.
3. A_time=5, B_time=0:
   - an[3] low→seg 7F (blank);
   - an[2]→12;
   - an[1]→7F;
   - an[0]→40.
4. A_time=63, B_time=59:
   - digits show 02, 30, 12, 10.
   - Check the max-value conversion has no carry overflow.
5. Change A_time 27→12 one cycle after a frame start:
   - the display keeps "27" for the rest of that frame;
   - "12" appears only after the next frame start plus 7 cycles.
6. Assert RST 3 cycles after a frame start (converter in CONV):
   - next edge: seg=7F, an=F, FSM=IDLE;
   - after release, the first valid digits match scenario 1 timing.
